i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
Shares one i2c_controller byte engine between NUM_REQ requesters, e.g. requester 0 = LCD init sequencer, requester 1 = runtime text writer, both targeting the display at 7'h3c.
- Grants the bus round-robin, one whole transaction at a time.
- Streams each granted requester's bytes into the controller's addr/data_in/rw/enable/ready interface.
- Enforces the post-byte settle delay, so requesters no longer hand-roll enable/ready timing.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
SETTLE_CYCLES, 6, cycles to hold a byte after hand-off before sampling ctl_ready again (lets ready deassert).
IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
clk  input  1  system clock (the controller's low-speed clock domain).
rst  input  1  synchronous, active-high reset.
req  input  NUM_REQ  requester i wants the bus; level, sampled only in IDLE.
req_addr  input  NUM_REQ*7  7-bit target address per requester; slice i = bits [7i+6:7i].
req_rw  input  NUM_REQ  direction per requester; 0 = write.
req_data  input  NUM_REQ*8  current byte per requester; slice i = bits [8i+7:8i].
req_last  input  NUM_REQ  current byte is the final byte of requester i's transaction.
gnt  output  NUM_REQ  one-hot grant; held for the whole transaction.
byte_ack  output  NUM_REQ  1-cycle pulse: current byte taken; requester presents its next byte from the following cycle.
done  output  NUM_REQ  1-cycle pulse: transaction finished, bus released.
busy  output  1  high in any state except IDLE.
ctl_addr  output  7  to controller addr.
ctl_data  output  8  to controller data_in.
ctl_rw  output  1  to controller rw.
ctl_enable  output  1  to controller enable.
ctl_ready  input  1  from controller ready; high = can accept a byte / idle.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State = IDLE.
  - gnt, byte_ack, done, busy, ctl_enable, ctl_rw = 0; ctl_addr = 0; ctl_data = 0.
  - Round-robin pointer last_idx = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts immediately. ctl_enable drops on the reset edge. No done pulse is issued.
- IDLE:
  - If req != 0, select the first set bit searching from last_idx+1 with wrap. Register sel, gnt[sel], ctl_addr = req_addr[sel], ctl_rw = req_rw[sel]. Go to WAIT_READY.
  - gnt rises 1 cycle after req is seen.
  - ctl_addr and ctl_rw change only on this transition.
- WAIT_READY:
  - ctl_enable = 1.
  - On a cycle where ctl_ready = 1: register ctl_data = req_data[sel] and last_flag = req_last[sel]. Pulse byte_ack[sel] in the next cycle, coincident with the new ctl_data. Clear the settle counter. Go to SETTLE.
- SETTLE:
  - ctl_ready is ignored.
  - The counter runs for SETTLE_CYCLES cycles (0..SETTLE_CYCLES-1).
  - On expiry: if last_flag = 0, go to WAIT_READY. Otherwise set ctl_enable = 0 and go to RELEASE.
- RELEASE:
  - ctl_enable = 0.
  - When ctl_ready = 1 (controller idle after STOP): pulse done[sel], clear gnt, set last_idx = sel, go to IDLE.
  - done and gnt-clear occur on the same cycle.
- Requester rules:
  - req deasserted after grant is ignored. Only req_last ends a transaction.
  - req_data[sel] must be stable from gnt until byte_ack, and again between consecutive byte_acks.
  - Single-byte transaction: req_last = 1 on the first byte.
- Arbitration:
  - Simultaneous requests are resolved by round-robin only.
  - A requester holding req continuously cannot win twice in a row while another is pending.
- Throughput bound: minimum per byte = 1 (ready sample) + SETTLE_CYCLES cycles.
- Invariants:
  - gnt is one-hot or zero.
  - byte_ack and done are only ever asserted on the bit of sel.
  - busy = (state != IDLE).

Decomposition:
- Package i2c_arb_pkg holds:
  - state enum arb_state_t {IDLE, WAIT_READY, SETTLE, RELEASE};
  - localparam LCD_ADDR = 7'h3c;
  - SETTLE_CYCLES default.
- One sub-module rr_picker, combinational: inputs req and last_idx; outputs found and sel_idx. Reusable by later schedulers.
- Everything else lives in i2c_bus_arbiter.

Test Plan:
- Reset then req=2'b01, addr 7'h3c, bytes {8'h00, 8'h38 last}, controller model raising ready 3 cycles after each byte -> ctl_addr=7'h3c, ctl_data sequence 00 then 38, byte_ack[0] ×2 spaced ≥7 cycles, ctl_enable low after the 2nd settle, done[0] once, gnt=0.
- req=2'b11 from IDLE after reset -> requester 0 granted first; after done[0], requester 1 granted with its addr/data; a third back-to-back request from both -> requester 0 again (strict alternation).
- Requester 0 with 13-byte init stream {78,00,38,39,14,78,5e,6d,0c,01,06,40,41}, last on 8'h41 -> exactly 13 byte_acks, ctl_data order matches, single done, ctl_enable continuously high until the final settle.
- ctl_ready held 0 for 50 cycles in WAIT_READY -> no byte_ack, ctl_data unchanged, ctl_enable=1 held; ready rises -> byte accepted next cycle.
- rst asserted during SETTLE of byte 2 -> next cycle all outputs zero, no done pulse; req=2'b10 afterwards -> requester 1 granted? No: pointer reset, so with req=2'b11 requester 0 wins; with req=2'b10 requester 1 wins.
- req[1] dropped one cycle after gnt[1] -> transaction continues to req_last, done[1] pulses, no spurious grant.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter and its round-robin picker.
package i2c_arb_pkg;

  localparam int unsigned ADDR_W            = 7;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned SETTLE_CYCLES_DEF = 6;

  localparam logic [ADDR_W-1:0] LCD_ADDR = 7'h3c;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    SETTLE     = 2'd2,
    RELEASE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_idx, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   sel_idx
);

  logic             hit_hi;
  logic             hit_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Lowest requester above last_idx wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = IDX_W'(i);
      end
      if (req[i] && !hit_hi && (IDX_W'(i) > last_idx)) begin
        hit_hi = 1'b1;
        idx_hi = IDX_W'(i);
      end
    end
    found   = hit_lo;
    sel_idx = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine between NUM_REQ requesters,
// streaming bytes with a fixed post-byte settle delay.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        byte_ack,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ctl_addr,
  output logic [DATA_W-1:0]         ctl_data,
  output logic                      ctl_rw,
  output logic                      ctl_enable,
  input  logic                      ctl_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               last_flag_q, last_flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] byte_ack_q, byte_ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               enable_q, enable_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic               pick_rw;
  logic [DATA_W-1:0]  cur_data;
  logic               cur_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req),
    .last_idx (last_idx_q),
    .found    (pick_found),
    .sel_idx  (pick_idx)
  );

  // Per-requester slice muxes: address/dir of the candidate, byte/last of the owner.
  always_comb begin
    pick_addr = '0;
    pick_rw   = 1'b0;
    cur_data  = '0;
    cur_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_addr = req_addr[ADDR_W*i +: ADDR_W];
        pick_rw   = req_rw[i];
      end
      if (sel_q == IDX_W'(i)) begin
        cur_data = req_data[DATA_W*i +: DATA_W];
        cur_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (pick_found) state_d = WAIT_READY;
      WAIT_READY: if (ctl_ready) state_d = SETTLE;
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = last_flag_q ? RELEASE : WAIT_READY;
      end
      RELEASE:    if (ctl_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    sel_d       = sel_q;
    last_idx_d  = last_idx_q;
    last_flag_d = last_flag_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    data_d      = data_q;
    byte_ack_d  = '0;
    done_d      = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d  = pick_idx;
          gnt_d  = NUM_REQ'(1) << pick_idx;
          addr_d = pick_addr;
          rw_d   = pick_rw;
        end
      end
      WAIT_READY: begin
        if (ctl_ready) begin
          data_d      = cur_data;
          last_flag_d = cur_last;
          byte_ack_d  = NUM_REQ'(1) << sel_q;
          cnt_d       = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
      end
      RELEASE: begin
        if (ctl_ready) begin
          done_d     = NUM_REQ'(1) << sel_q;
          gnt_d      = '0;
          last_idx_d = sel_q;
        end
      end
      default: ;
    endcase
    busy_d   = (state_d != IDLE);
    enable_d = (state_d == WAIT_READY) || (state_d == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      last_flag_q <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      byte_ack_q  <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      enable_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      sel_q       <= sel_d;
      last_idx_q  <= last_idx_d;
      last_flag_q <= last_flag_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      byte_ack_q  <= byte_ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      enable_q    <= enable_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign gnt        = gnt_q;
  assign byte_ack   = byte_ack_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign ctl_addr   = addr_q;
  assign ctl_data   = data_q;
  assign ctl_rw     = rw_q;
  assign ctl_enable = enable_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: directed requester streams, a simple
// controller model, and a monitor that checks every byte_ack/done against expectations.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned SC = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req;
  logic [NR*7-1:0]   req_addr;
  logic [NR-1:0]     req_rw;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     byte_ack;
  logic [NR-1:0]     done;
  logic              busy;
  logic [6:0]        ctl_addr;
  logic [7:0]        ctl_data;
  logic              ctl_rw;
  logic              ctl_enable;
  logic              ctl_ready;

  i2c_bus_arbiter #(.NUM_REQ(NR), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_data(req_data), .req_last(req_last), .gnt(gnt), .byte_ack(byte_ack),
    .done(done), .busy(busy), .ctl_addr(ctl_addr), .ctl_data(ctl_data),
    .ctl_rw(ctl_rw), .ctl_enable(ctl_enable), .ctl_ready(ctl_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    bit         first;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Requester-side stimulus state
  logic [7:0] rq_bytes [NR][16];
  int         rq_len [NR] = '{default: 0};
  logic [6:0] rq_addr [NR] = '{default: 7'h00};
  logic       rq_rw [NR] = '{default: 1'b0};
  int         rounds_req [NR] = '{default: 0};
  int         rounds_done [NR] = '{default: 0};
  int         ptr [NR] = '{default: 0};
  bit         drop [NR] = '{default: 1'b0};
  logic [7:0] stage [16];
  bit         force_low = 1'b0;
  int         hold = 0;

  logic [7:0] init_seq [13] = '{8'h78, 8'h00, 8'h38, 8'h39, 8'h14, 8'h78, 8'h5e,
                                8'h6d, 8'h0c, 8'h01, 8'h06, 8'h40, 8'h41};

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [6:0] a, input logic rw, input int n);
    rq_addr[idx] = a;
    rq_rw[idx]   = rw;
    rq_len[idx]  = n;
    for (int b = 0; b < n; b++) rq_bytes[idx][b] = stage[b];
  endtask

  task automatic expect_txn(input int idx, input int n_acks, input bit with_done);
    exp_t e;
    for (int b = 0; b < n_acks; b++) begin
      e.is_done = 1'b0; e.idx = idx; e.addr = rq_addr[idx]; e.rw = rq_rw[idx];
      e.data = rq_bytes[idx][b]; e.first = (b == 0);
      sb.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1; e.idx = idx; e.addr = rq_addr[idx]; e.rw = rq_rw[idx];
      e.data = 8'h00; e.first = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && rounds_done[0] == rounds_req[0] &&
          rounds_done[1] == rounds_req[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requesters: advance on byte_ack, finish a round on done, hold req while rounds remain
  initial begin : drv
    req = '0; req_addr = '0; req_rw = '0; req_data = '0; req_last = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rst) begin
          rounds_done[i] = rounds_req[i];
          ptr[i] = 0;
        end else begin
          if (byte_ack[i]) ptr[i]++;
          if (done[i]) begin
            rounds_done[i]++;
            ptr[i] = 0;
          end
        end
        req[i]            = (rounds_done[i] < rounds_req[i]) && !drop[i];
        req_addr[7*i +: 7] = rq_addr[i];
        req_rw[i]         = rq_rw[i];
        req_data[8*i +: 8] = rq_bytes[i][(ptr[i] < rq_len[i]) ? ptr[i] : 0];
        req_last[i]       = (ptr[i] == rq_len[i] - 1);
      end
    end
  end

  // Controller model: ready drops for 3 cycles after each byte hand-off
  initial begin : ctl
    ctl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (byte_ack != '0) hold = 3;
      else if (hold > 0) hold--;
      ctl_ready = !force_low && (hold == 0);
    end
  end

  // Monitor: pop and compare whenever the DUT presents byte_ack or done
  initial begin : mon
    exp_t e;
    int   cyc;
    int   last_ack;
    cyc = 0;
    last_ack = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (byte_ack != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(byte_ack), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_kind", 32'(e.is_done), 32'd0);
          chk("ack_onehot", 32'(byte_ack), 32'(oh(e.idx)));
          chk("ack_gnt", 32'(gnt), 32'(oh(e.idx)));
          chk("ack_data", 32'(ctl_data), 32'(e.data));
          chk("ack_addr", 32'(ctl_addr), 32'(e.addr));
          chk("ack_rw", 32'(ctl_rw), 32'(e.rw));
          chk("ack_enable", 32'(ctl_enable), 32'd1);
          if (!e.first) chk("ack_gap_ok", 32'((cyc - last_ack) >= int'(1 + SC)), 32'd1);
          last_ack = cyc;
        end
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 32'(e.is_done), 32'd1);
          chk("done_onehot", 32'(done), 32'(oh(e.idx)));
          chk("done_gnt_clear", 32'(gnt), 32'd0);
          chk("done_enable", 32'(ctl_enable), 32'd0);
        end
      end
    end
  end

  initial begin : main
    int k;
    int cnt;
    int acks;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'(ctl_enable), 32'd0);
    chk("rst_addr", 32'(ctl_addr), 32'd0);
    chk("rst_data", 32'(ctl_data), 32'd0);
    chk("rst_ack_done", 32'({byte_ack, done}), 32'd0);

    // Two-byte write to the LCD from requester 0
    stage[0] = 8'h00; stage[1] = 8'h38;
    load(0, LCD_ADDR, 1'b0, 2);
    expect_txn(0, 2, 1'b1);
    rounds_req[0]++;
    wait_idle("t1_idle", 200);

    // Both requesters held for two rounds each: strict alternation 0,1,0,1
    do_reset();
    stage[0] = 8'h40;
    load(0, LCD_ADDR, 1'b0, 1);
    stage[0] = 8'h55; stage[1] = 8'h66;
    load(1, 7'h3d, 1'b1, 2);
    expect_txn(0, 1, 1'b1);
    expect_txn(1, 2, 1'b1);
    expect_txn(0, 1, 1'b1);
    expect_txn(1, 2, 1'b1);
    rounds_req[0] += 2;
    rounds_req[1] += 2;
    wait_idle("t2_idle", 400);

    // 13-byte init stream; enable must stay high except the single release cycle
    for (int b = 0; b < 13; b++) stage[b] = init_seq[b];
    load(0, LCD_ADDR, 1'b0, 13);
    expect_txn(0, 13, 1'b1);
    rounds_req[0]++;
    cnt = 0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (gnt[0] && !ctl_enable) cnt++;
      if (done[0]) break;
    end
    chk("t3_enable_low_cycles", 32'(cnt), 32'd1);
    wait_idle("t3_idle", 50);

    // Controller stalls in WAIT_READY for 50 cycles
    force_low = 1'b1;
    stage[0] = 8'ha5;
    load(0, LCD_ADDR, 1'b0, 1);
    expect_txn(0, 1, 1'b1);
    rounds_req[0]++;
    for (k = 0; k < 20 && !gnt[0]; k++) @(negedge clk);
    chk("t4_granted", 32'(gnt), 32'(oh(0)));
    acks = 0; cnt = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (byte_ack != '0) acks++;
      if (!ctl_enable || ctl_data != 8'h41) cnt++;
    end
    chk("t4_no_ack", 32'(acks), 32'd0);
    chk("t4_hold_en_data", 32'(cnt), 32'd0);
    force_low = 1'b0;
    for (k = 0; k < 5 && !ctl_ready; k++) @(negedge clk);
    @(negedge clk);
    chk("t4_accept_next", 32'(byte_ack), 32'(oh(0)));
    wait_idle("t4_idle", 50);

    // Reset during settle of byte 2 aborts without done
    stage[0] = 8'h01; stage[1] = 8'h02; stage[2] = 8'h03;
    load(0, LCD_ADDR, 1'b0, 3);
    expect_txn(0, 2, 1'b0);
    rounds_req[0]++;
    acks = 0;
    for (k = 0; k < 200 && acks < 2; k++) begin
      @(negedge clk);
      if (byte_ack[0]) acks++;
    end
    chk("t5_two_acks", 32'(acks), 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_enable", 32'(ctl_enable), 32'd0);
    chk("t5_rst_data_addr", 32'({ctl_addr, ctl_data}), 32'd0);
    cnt = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done != '0) cnt++;
    end
    chk("t5_no_done", 32'(cnt), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // After reset the pointer favours requester 0 on a tie
    expect_txn(0, 3, 1'b1);
    expect_txn(1, 2, 1'b1);
    rounds_req[0]++;
    rounds_req[1]++;
    wait_idle("t5_tie_idle", 300);
    do_reset();
    expect_txn(1, 2, 1'b1);
    rounds_req[1]++;
    wait_idle("t5_solo1_idle", 200);

    // Requester 1 drops req right after grant; transaction still completes
    expect_txn(1, 2, 1'b1);
    rounds_req[1]++;
    for (k = 0; k < 20 && !gnt[1]; k++) @(negedge clk);
    chk("t6_granted", 32'(gnt), 32'(oh(1)));
    @(negedge clk);
    drop[1] = 1'b1;
    wait_idle("t6_idle", 200);
    repeat (5) @(negedge clk);
    chk("t6_no_regrant", 32'({gnt, busy}), 32'd0);
    drop[1] = 1'b0;

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
